stall_cnt_dump: RTL and testbench

//  Readout side of the per-operator stall counters. Snapshots NUM_OPS 32-bit counters

---
 rtl/stall_dump_pkg.sv | 24 ++
 rtl/stall_snap_bank.sv | 42 ++++
 rtl/stall_cnt_dump.sv | 144 ++++++++++++++
 tb/tb_stall_cnt_dump.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stall_dump_pkg.sv
// Shared types and header layout for the stall-counter dump path.
package stall_dump_pkg;

  typedef enum logic [2:0] {IDLE, SNAP, HDR, DATA, DONE} state_t;

  localparam int          DEF_CNT_W     = 32;
  localparam logic [15:0] DEF_HDR_MAGIC = 16'hA5C0;

  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_NOPS_LSB  = 8;
  localparam int HDR_SEQ_LSB   = 0;

  function automatic logic [31:0] build_hdr(input logic [15:0] magic,
                                            input logic [7:0]  nops,
                                            input logic [7:0]  seq);
    logic [31:0] w_hdr;
    w_hdr = '0;
    w_hdr[HDR_MAGIC_LSB +: 16] = magic;
    w_hdr[HDR_NOPS_LSB  +: 8]  = nops;
    w_hdr[HDR_SEQ_LSB   +: 8]  = seq;
    return w_hdr;
  endfunction

endpackage

// File: rtl/stall_snap_bank.sv
// Shadow copy of all operator stall counters, loaded atomically on one edge,
// with a registered read port indexed by the word the streamer needs next.
module stall_snap_bank #(
  parameter int NUM_OPS = 8,
  parameter int CNT_W   = 32,
  parameter int IDX_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_load,
  input  logic [NUM_OPS*CNT_W-1:0] i_cnt_flat,
  input  logic [IDX_W-1:0]         i_rd_idx,
  output logic [CNT_W-1:0]         o_word
);

  logic [CNT_W-1:0] r_shadow [NUM_OPS];
  logic [CNT_W-1:0] r_word;
  logic [CNT_W-1:0] w_sel;

  // Out-of-range index (one past the last counter) reads as zero.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (i_rd_idx == IDX_W'(i)) w_sel = r_shadow[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OPS; i++) r_shadow[i] <= '0;
      r_word <= '0;
    end else begin
      if (i_load) begin
        for (int i = 0; i < NUM_OPS; i++) r_shadow[i] <= i_cnt_flat[i*CNT_W +: CNT_W];
      end
      r_word <= w_sel;
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/stall_cnt_dump.sv
// Snapshots the operator stall counters and streams header + counters out a
// valid/ready port.
//   state | meaning
//   IDLE  | waiting for a trigger or a pending request
//   SNAP  | shadow bank loads every counter on this edge
//   HDR   | first cycle loads the header into dout, then waits for accept
//   DATA  | streams shadow words; r_idx is the next word to move into dout
//   DONE  | one-cycle dump_done pulse, sequence number advances
module stall_cnt_dump
  import stall_dump_pkg::*;
#(
  parameter int          NUM_OPS   = 8,
  parameter int          CNT_W     = DEF_CNT_W,
  parameter logic [15:0] HDR_MAGIC = DEF_HDR_MAGIC,
  parameter bit          AUTO_DUMP = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_OPS-1:0]       done_vec,
  input  logic [NUM_OPS*CNT_W-1:0] stall_cnt_flat,
  input  logic                     dump_req,
  output logic [CNT_W-1:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     busy,
  output logic                     dump_done
);

  localparam int             IDX_W    = $clog2(NUM_OPS + 1);
  localparam logic [7:0]     NOPS8    = 8'(NUM_OPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS);

  state_t            r_state, w_state_nxt;
  logic              r_done_all_q, r_pending;
  logic [7:0]        r_seq;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [CNT_W-1:0]  r_dout, w_dout_nxt, w_word, w_hdr;
  logic              r_valid, w_valid_nxt;
  logic              r_busy, r_dump_done;
  logic              w_all_done, w_trigger, w_accept;

  assign w_all_done = &done_vec;
  assign w_trigger  = dump_req | (AUTO_DUMP & w_all_done & ~r_done_all_q);
  assign w_accept   = r_valid & dout_ready;
  assign w_hdr      = CNT_W'(build_hdr(HDR_MAGIC, NOPS8, r_seq));

  stall_snap_bank #(
    .NUM_OPS (NUM_OPS),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W)
  ) u_bank (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (r_state == SNAP),
    .i_cnt_flat (stall_cnt_flat),
    .i_rd_idx   (w_idx_nxt),
    .o_word     (w_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_trigger || r_pending) w_state_nxt = SNAP;
      SNAP: w_state_nxt = HDR;
      HDR:  if (w_accept) w_state_nxt = DATA;
      DATA: if (w_accept && (r_idx == LAST_IDX)) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values for the registered stream outputs; the bank is addressed with
  // w_idx_nxt so its registered word is always shadow[r_idx].
  always_comb begin
    w_dout_nxt  = r_dout;
    w_valid_nxt = r_valid;
    w_idx_nxt   = r_idx;
    case (r_state)
      SNAP: begin
        w_idx_nxt   = '0;
        w_dout_nxt  = '0;
        w_valid_nxt = 1'b0;
      end
      HDR: begin
        if (!r_valid) begin
          w_valid_nxt = 1'b1;
          w_dout_nxt  = w_hdr;
        end else if (dout_ready) begin
          w_dout_nxt = w_word;
          w_idx_nxt  = r_idx + IDX_W'(1);
        end
      end
      DATA: begin
        if (w_accept) begin
          if (r_idx == LAST_IDX) begin
            w_valid_nxt = 1'b0;
            w_dout_nxt  = '0;
          end else begin
            w_dout_nxt = w_word;
            w_idx_nxt  = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_dout_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout       <= '0;
      r_valid      <= 1'b0;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_dump_done  <= 1'b0;
      r_seq        <= '0;
      r_pending    <= 1'b0;
      r_done_all_q <= 1'b0;
    end else begin
      r_dout       <= w_dout_nxt;
      r_valid      <= w_valid_nxt;
      r_idx        <= w_idx_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_dump_done  <= (w_state_nxt == DONE);
      r_done_all_q <= w_all_done;
      if (r_state == DONE) r_seq <= r_seq + 8'd1;
      if (w_trigger && (r_state != IDLE)) r_pending <= 1'b1;
      else if (r_state == SNAP)           r_pending <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign busy       = r_busy;
  assign dump_done  = r_dump_done;

endmodule

// File: tb/tb_stall_cnt_dump.sv
// Scoreboard bench for stall_cnt_dump: a 4-operator instance for timing,
// backpressure, pending and reset behaviour, and a 1-operator instance for
// sequence-number wrap.
module tb_stall_cnt_dump;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rst_b_n = 1'b0;

  logic [N-1:0]   done_vec = '0;
  logic [N*W-1:0] cnt_flat;
  logic           dump_req = 1'b0;
  logic           dout_ready = 1'b1;
  logic [W-1:0]   dout;
  logic           dout_valid, busy, dump_done;

  logic [0:0]     done_b = '0;
  logic [W-1:0]   cnt_b = 32'hCAFE0001;
  logic           req_b = 1'b0;
  logic           ready_b = 1'b1;
  logic [W-1:0]   dout_b;
  logic           valid_b, busy_b, done_pulse_b;

  int             n_chk = 0;
  int             n_pass = 0;
  int             n_acc = 0;
  logic [31:0]    exp_q[$];
  logic [31:0]    cur_cnt [N];
  logic [7:0]     exp_seq = '0;
  bit             inc_en = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < N; i++) cnt_flat[i*W +: W] = cur_cnt[i];
  end

  stall_cnt_dump #(.NUM_OPS(N), .CNT_W(W), .HDR_MAGIC(16'hA5C0), .AUTO_DUMP(1'b1)) dut (
    .clk(clk), .reset_n(rst_n), .done_vec(done_vec), .stall_cnt_flat(cnt_flat),
    .dump_req(dump_req), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .dump_done(dump_done));

  stall_cnt_dump #(.NUM_OPS(1), .CNT_W(W), .HDR_MAGIC(16'hA5C0), .AUTO_DUMP(1'b1)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .done_vec(done_b), .stall_cnt_flat(cnt_b),
    .dump_req(req_b), .dout(dout_b), .dout_valid(valid_b), .dout_ready(ready_b),
    .busy(busy_b), .dump_done(done_pulse_b));

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endfunction

  // Monitor for the 4-op instance: scoreboard pops, stall stability, idle zero.
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [31:0] prev_d = '0;
  always @(negedge clk) begin
    if (prev_v && !prev_r) begin
      chk("hold_valid", {31'b0, dout_valid}, 32'd1);
      chk("hold_data", dout, prev_d);
    end
    if (dout_valid && dout_ready) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_beat: got %h expected no beat", dout);
      end else begin
        chk("beat", dout, exp_q.pop_front());
      end
    end
    if (!dout_valid) chk("idle_dout_zero", dout, 32'd0);
    prev_v = dout_valid;
    prev_r = dout_ready;
    prev_d = dout;
  end

  // Monitor for the 1-op instance: header/word alternation with wrapping seq.
  logic [7:0] b_seq = '0;
  bit         b_phase = 1'b0;
  always @(negedge clk) begin
    if (valid_b && ready_b) begin
      if (!b_phase) chk("b_hdr", dout_b, {16'hA5C0, 8'h01, b_seq});
      else begin
        chk("b_word", dout_b, 32'hCAFE0001);
        b_seq = b_seq + 8'd1;
      end
      b_phase = ~b_phase;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (inc_en) for (int i = 0; i < N; i++) cur_cnt[i] = cur_cnt[i] + 32'd1;
  endtask

  task automatic pulse_req();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
  endtask

  task automatic push_dump();
    exp_q.push_back({16'hA5C0, 8'h04, exp_seq});
    for (int i = 0; i < N; i++) exp_q.push_back(cur_cnt[i]);
  endtask

  // mode 0: ready held high; mode 1: 1010.. with a 5-cycle stall mid-DATA.
  task automatic wait_done(input int budget, input int mode);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      if (mode == 1) dout_ready = (c >= 8 && c < 13) ? 1'b0 : ~c[0];
      else           dout_ready = 1'b1;
      tick();
      if (dump_done) seen = 1'b1;
    end
    chk("dump_done_seen", {31'b0, seen}, 32'd1);
    dout_ready = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, nd;
    cur_cnt = '{32'd10, 32'd20, 32'd30, 32'd40};
    tick(); tick();
    #2 rst_n = 1'b1; rst_b_n = 1'b1;
    tick();
    chk("rst_valid", {31'b0, dout_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, dump_done}, 32'd0);
    chk("rst_dout", dout, 32'd0);

    // 1: latency and dump_done/busy timing
    push_dump();
    pulse_req();
    chk("busy_in_snap", {31'b0, busy}, 32'd1);
    chk("valid_in_snap", {31'b0, dout_valid}, 32'd0);
    tick();
    chk("hdr_not_yet", {31'b0, dout_valid}, 32'd0);
    tick();
    chk("hdr_valid_k2", {31'b0, dout_valid}, 32'd1);
    chk("hdr_word", dout, 32'hA5C0_0400);
    repeat (4) tick();
    chk("done_not_early", {31'b0, dump_done}, 32'd0);
    tick();
    chk("dump_done_pulse", {31'b0, dump_done}, 32'd1);
    chk("busy_in_done", {31'b0, busy}, 32'd1);
    tick();
    chk("done_cleared", {31'b0, dump_done}, 32'd0);
    chk("busy_cleared", {31'b0, busy}, 32'd0);
    exp_seq++;
    chk("q_empty_t1", exp_q.size(), 32'd0);

    // 2: backpressure
    push_dump();
    pulse_req();
    n0 = n_acc;
    wait_done(60, 1);
    chk("accepted_beats", n_acc - n0, 32'd5);
    exp_seq++;
    tick();
    chk("q_empty_t2", exp_q.size(), 32'd0);

    // 3: live counters move during dump; stream shows SNAP-edge values
    inc_en = 1'b1;
    exp_q.push_back({16'hA5C0, 8'h04, exp_seq});
    pulse_req();
    for (int i = 0; i < N; i++) exp_q.push_back(cur_cnt[i]);
    wait_done(40, 0);
    inc_en = 1'b0;
    exp_seq++;
    tick();
    chk("q_empty_t3", exp_q.size(), 32'd0);

    // 4: merged pending requests, then auto trigger
    cur_cnt = '{32'd5, 32'd6, 32'd7, 32'd8};
    push_dump();
    pulse_req();
    tick(); tick();
    pulse_req();
    tick();
    pulse_req();
    wait_done(40, 0);
    pulse_req();
    exp_seq++;
    push_dump();
    wait_done(40, 0);
    exp_seq++;
    repeat (10) tick();
    chk("pending_one_extra", {31'b0, busy}, 32'd0);
    chk("q_empty_t4", exp_q.size(), 32'd0);

    push_dump();
    done_vec = '1;
    tick();
    wait_done(40, 0);
    exp_seq++;
    repeat (12) tick();
    chk("auto_no_repeat", {31'b0, busy}, 32'd0);
    chk("q_empty_auto", exp_q.size(), 32'd0);
    done_vec = '0;
    tick();

    // 5: asynchronous reset mid-DATA
    push_dump();
    pulse_req();
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, dout_valid}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_dout", dout, 32'd0);
    exp_q.delete();
    tick(); tick();
    #3 rst_n = 1'b1;
    tick();
    exp_seq = '0;
    cur_cnt = '{32'd100, 32'd200, 32'd300, 32'd400};
    push_dump();
    pulse_req();
    wait_done(40, 0);
    tick();
    chk("q_empty_t5", exp_q.size(), 32'd0);

    // 6: back-to-back dumps on the 1-op instance, seq wraps 255 -> 0
    nd = 0;
    req_b = 1'b1;
    for (int c = 0; c < 3000 && nd < 257; c++) begin
      tick();
      if (done_pulse_b) nd++;
    end
    req_b = 1'b0;
    chk("b_dump_count", nd, 32'd257);
    repeat (20) tick();
    chk("b_idle", {31'b0, busy_b}, 32'd0);
    chk("b_seq_final", {24'b0, b_seq}, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
